pulse_window_counter: RTL and testbench

- Front-end producer of the pulse_count bus read by the BPM monitor.
- Conditions the raw heartbeat sensor line: synchroniser, debounce, rising-edge detect and refractory blanking.
- Counts accepted beats over a fixed window and publishes the result once per window with a 1-cycle valid strobe.
- Default 6 s window at 1 MHz, so BPM = pulse_count x 10 downstream.

---
 rtl/pulse_window_counter.sv | 156 +++++++++++++++
 tb/tb_pulse_window_counter.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/pulse_window_counter.sv
// pulse_window_counter: conditions a raw heartbeat sensor line and counts accepted beats over a
// fixed window, publishing the count once per window.
//
// Conditioning chain: 2-flop synchroniser -> debounce filter -> rising-edge detect ->
// refractory blanking. Accepted beats are accumulated (saturating) while counting is enabled.
//
// Ports:
//   clk         in   system clock, rising edge
//   reset       in   asynchronous active-low reset
//   enable      in   counting enable (synchronous)
//   pulse_in    in   raw sensor line, asynchronous to clk
//   pulse_count out  beats in the last completed window
//   count_valid out  1-cycle strobe, pulse_count just updated
//   pulse_seen  out  1-cycle strobe per accepted beat
//   overflow    out  last published window saturated
//   no_signal   out  last published window had zero beats
module pulse_window_counter #(
  parameter int unsigned WINDOW_CYC     = 6000000,
  parameter int unsigned DEBOUNCE_CYC   = 1000,
  parameter int unsigned REFRACTORY_CYC = 250000,
  parameter int unsigned COUNT_W        = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic               pulse_in,
  output logic [COUNT_W-1:0] pulse_count,
  output logic               count_valid,
  output logic               pulse_seen,
  output logic               overflow,
  output logic               no_signal
);

  localparam int unsigned WinW = (WINDOW_CYC > 1) ? $clog2(WINDOW_CYC) : 1;
  localparam int unsigned DbW  = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
  localparam int unsigned RefW = (REFRACTORY_CYC > 1) ? $clog2(REFRACTORY_CYC) : 1;

  localparam logic [WinW-1:0] WinLast = WinW'(WINDOW_CYC - 1);
  localparam logic [DbW-1:0]  DbLast  = DbW'(DEBOUNCE_CYC - 1);
  localparam logic [RefW-1:0] RefLast = RefW'(REFRACTORY_CYC - 1);

  typedef enum logic [0:0] {StIdle, StCount} state_e;

  state_e             state_q;
  logic [1:0]         sync_q;
  logic               filt_q;
  logic               filt_prev_q;
  logic [DbW-1:0]     db_cnt_q;
  logic [RefW-1:0]    refr_q;
  logic [WinW-1:0]    win_q;
  logic [COUNT_W-1:0] acc_q;
  logic               sat_q;

  logic               cand;
  logic               accept;
  logic               acc_max;
  logic               win_end;
  logic [COUNT_W-1:0] acc_d;
  logic               sat_d;

  // acc_d/sat_d include a beat accepted this cycle, so a beat landing on the last window
  // cycle is published rather than lost.
  always_comb begin
    cand    = filt_q & ~filt_prev_q;
    accept  = (state_q == StCount) && enable && cand && (refr_q == '0);
    acc_max = &acc_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    if (accept) begin
      if (acc_max) begin
        sat_d = 1'b1;
      end else begin
        acc_d = acc_q + COUNT_W'(1);
      end
    end
    win_end = (state_q == StCount) && enable && (win_q == WinLast);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      sync_q      <= '0;
      filt_q      <= 1'b0;
      filt_prev_q <= 1'b0;
      db_cnt_q    <= '0;
      refr_q      <= '0;
      win_q       <= '0;
      acc_q       <= '0;
      sat_q       <= 1'b0;
      pulse_count <= '0;
      count_valid <= 1'b0;
      pulse_seen  <= 1'b0;
      overflow    <= 1'b0;
      no_signal   <= 1'b0;
    end else begin
      // Conditioning runs regardless of FSM state so the filter level survives enable toggles.
      sync_q <= {sync_q[0], pulse_in};
      if (sync_q[1] != filt_q) begin
        if (db_cnt_q == DbLast) begin
          filt_q   <= ~filt_q;
          db_cnt_q <= '0;
        end else begin
          db_cnt_q <= db_cnt_q + DbW'(1);
        end
      end else begin
        db_cnt_q <= '0;
      end
      filt_prev_q <= filt_q;

      pulse_seen  <= accept;
      count_valid <= 1'b0;

      unique case (state_q)
        StIdle: begin
          win_q  <= '0;
          acc_q  <= '0;
          sat_q  <= 1'b0;
          refr_q <= '0;
          if (enable) state_q <= StCount;
        end
        StCount: begin
          if (!enable) begin
            // Partial window is dropped without a strobe.
            state_q <= StIdle;
            win_q   <= '0;
            acc_q   <= '0;
            sat_q   <= 1'b0;
            refr_q  <= '0;
          end else begin
            // Refractory timer is independent of the window boundary.
            if (accept) begin
              refr_q <= RefLast;
            end else if (refr_q != '0) begin
              refr_q <= refr_q - RefW'(1);
            end
            if (win_end) begin
              pulse_count <= acc_d;
              overflow    <= sat_d;
              no_signal   <= (acc_d == '0);
              count_valid <= 1'b1;
              win_q       <= '0;
              acc_q       <= '0;
              sat_q       <= 1'b0;
            end else begin
              win_q <= win_q + WinW'(1);
              acc_q <= acc_d;
              sat_q <= sat_d;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_pulse_window_counter.sv
// Directed bench for pulse_window_counter. Two instances share all stimulus: an 8-bit one
// checked throughout and a 4-bit one used for the saturation scenario.
module tb_pulse_window_counter;

  localparam int unsigned Win = 1000;
  localparam int unsigned Deb = 4;
  localparam int unsigned Ref = 20;

  logic       clk;
  logic       reset;
  logic       enable;
  logic       pulse_in;
  logic [7:0] pc8;
  logic       cv8, ps8, ov8, ns8;
  logic [3:0] pc4;
  logic       cv4, ps4, ov4, ns4;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  int seen_cnt = 0;
  int valid_cnt = 0;
  int last_seen_cyc = 0;
  int rise_cyc = 0;

  pulse_window_counter #(
    .WINDOW_CYC(Win), .DEBOUNCE_CYC(Deb), .REFRACTORY_CYC(Ref), .COUNT_W(8)
  ) u_dut8 (
    .clk(clk), .reset(reset), .enable(enable), .pulse_in(pulse_in),
    .pulse_count(pc8), .count_valid(cv8), .pulse_seen(ps8), .overflow(ov8), .no_signal(ns8)
  );

  pulse_window_counter #(
    .WINDOW_CYC(Win), .DEBOUNCE_CYC(Deb), .REFRACTORY_CYC(Ref), .COUNT_W(4)
  ) u_dut4 (
    .clk(clk), .reset(reset), .enable(enable), .pulse_in(pulse_in),
    .pulse_count(pc4), .count_valid(cv4), .pulse_seen(ps4), .overflow(ov4), .no_signal(ns4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ps8) begin
      seen_cnt++;
      last_seen_cyc = cyc;
    end
    if (cv8) valid_cnt++;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Rise #1 after a posedge, high for hi cycles, low for lo cycles; period hi+lo+1.
  task automatic pulse(input int hi, input int lo);
    @(posedge clk);
    #1;
    pulse_in = 1'b1;
    rise_cyc = cyc;
    repeat (hi) @(posedge clk);
    #1;
    pulse_in = 1'b0;
    repeat (lo) @(posedge clk);
  endtask

  task automatic wait_valid(input string tag, input int budget, output int at);
    bit found = 1'b0;
    at = -1;
    for (int i = 0; i < budget && !found; i++) begin
      @(negedge clk);
      if (cv8) begin
        found = 1'b1;
        at = cyc;
      end
    end
    if (!found) check_eq({tag, "_timeout"}, 0, 1);
  endtask

  initial begin
    int en_cyc;
    int at;
    int seen_base;
    int valid_base;
    int v_cyc;

    reset    = 1'b0;
    enable   = 1'b0;
    pulse_in = 1'b0;
    #12;
    check_eq("rst_count", pc8, 0);
    check_eq("rst_valid", cv8, 0);
    check_eq("rst_seen", ps8, 0);
    check_eq("rst_ovf", ov8, 0);
    check_eq("rst_nosig", ns8, 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (5) @(posedge clk);

    // 1: seven clean pulses, latency and window timing
    #1;
    enable = 1'b1;
    en_cyc = cyc;
    seen_base = seen_cnt;
    repeat (5) @(posedge clk);
    for (int i = 0; i < 7; i++) begin
      pulse(10, 49);
      check_eq("t1_latency", last_seen_cyc - rise_cyc, Deb + 3);
    end
    wait_valid("t1", 1100, at);
    check_eq("t1_valid_time", at - en_cyc, Win + 1);
    check_eq("t1_count", pc8, 7);
    check_eq("t1_ovf", ov8, 0);
    check_eq("t1_nosig", ns8, 0);
    check_eq("t1_seen", seen_cnt - seen_base, 7);

    // 2: glitches only
    seen_base = seen_cnt;
    for (int i = 0; i < 20; i++) pulse(1 + (i % 3), 20);
    wait_valid("t2", 1100, at);
    check_eq("t2_count", pc8, 0);
    check_eq("t2_nosig", ns8, 1);
    check_eq("t2_seen", seen_cnt - seen_base, 0);

    // 3: refractory rejects a rise 12 cycles after an accepted one
    seen_base = seen_cnt;
    pulse(8, 3);
    pulse(8, 19);
    pulse(8, 30);
    wait_valid("t3", 1100, at);
    check_eq("t3_count", pc8, 2);
    check_eq("t3_seen", seen_cnt - seen_base, 2);
    check_eq("t3_nosig", ns8, 0);

    // 4: twenty beats saturate the 4-bit instance
    for (int i = 0; i < 20; i++) pulse(10, 34);
    wait_valid("t4", 1100, at);
    check_eq("t4_w4_valid", cv4, 1);
    check_eq("t4_w4_count", pc4, 15);
    check_eq("t4_w4_ovf", ov4, 1);
    check_eq("t4_w4_nosig", ns4, 0);
    check_eq("t4_w8_count", pc8, 20);
    check_eq("t4_w8_ovf", ov8, 0);
    wait_valid("t4q", 1100, at);
    check_eq("t4q_w4_count", pc4, 0);
    check_eq("t4q_w4_ovf", ov4, 0);
    check_eq("t4q_w4_nosig", ns4, 1);

    // 5: reset mid-window after three beats
    for (int i = 0; i < 3; i++) pulse(10, 49);
    @(posedge clk);
    #1;
    reset  = 1'b0;
    enable = 1'b0;
    #2;
    check_eq("t5_async_count", pc8, 0);
    check_eq("t5_async_nosig", ns8, 0);
    check_eq("t5_async_w4_nosig", ns4, 0);
    check_eq("t5_async_valid", cv8, 0);
    check_eq("t5_async_seen", ps8, 0);
    check_eq("t5_async_ovf", ov8, 0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    enable = 1'b1;
    en_cyc = cyc;
    pulse(10, 49);
    pulse(10, 49);
    wait_valid("t5", 1100, at);
    check_eq("t5_valid_time", at - en_cyc, Win + 1);
    check_eq("t5_count", pc8, 2);
    check_eq("t5_nosig", ns8, 0);

    // 6: enable dropped at window cycle 500 after four beats
    v_cyc = at;
    seen_base = seen_cnt;
    for (int i = 0; i < 4; i++) pulse(10, 49);
    while (cyc < v_cyc + 500) begin
      @(posedge clk);
      #1;
    end
    enable = 1'b0;
    valid_base = valid_cnt;
    repeat (1200) @(posedge clk);
    check_eq("t6_no_valid", valid_cnt - valid_base, 0);
    check_eq("t6_hold_count", pc8, 2);
    check_eq("t6_seen", seen_cnt - seen_base, 4);
    #1;
    enable = 1'b1;
    en_cyc = cyc;
    wait_valid("t6", 1100, at);
    check_eq("t6_valid_time", at - en_cyc, Win + 1);
    check_eq("t6_count", pc8, 0);
    check_eq("t6_nosig", ns8, 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
